// File: rtl/approx_mult_denorm.sv
// approx_mult_denorm
// Back end of the approximate 16x16 multiplier. It takes the normalized 8-bit
// mantissas and the normalizer shift counts of both operands, forms the exact
// mantissa product with a sequential add-shift multiplier, then shifts it left
// by k = 2*MANT_W - sa - sb to restore the binary point.
//
// Optional feature: define APPROX_ROUND_EN to set bit k-1 of the result
// (half-LSB compensation for the truncated operand bits) whenever k >= 1.
//
// Handshake: start is sampled only in IDLE. busy is high from the cycle after
// capture until the done cycle inclusive. done is a one-cycle pulse and result
// holds its value until the next done. A start seen in any other state is
// dropped, never queued.
module approx_mult_denorm #(
    parameter int MANT_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MANT_W-1:0]    a_mant,
    input  logic [MANT_W-1:0]    b_mant,
    input  logic [SHIFT_W-1:0]   a_shift,
    input  logic [SHIFT_W-1:0]   b_shift,
    output logic                 busy,
    output logic                 done,
    output logic [4*MANT_W-1:0]  result,
    output logic [1:0]           dbg_state
);

    localparam int RES_W = 4 * MANT_W;
    localparam int ACC_W = 2 * MANT_W;
    localparam int K_W   = $clog2(ACC_W + 1);
    localparam int CNT_W = $clog2(MANT_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULT   = 2'd1;
    localparam logic [1:0] S_DENORM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [MANT_W-1:0]  mcand_q,  mcand_d;
    logic [MANT_W-1:0]  mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [K_W-1:0]     k_q,      k_d;
    logic [K_W-1:0]     dcnt_q,   dcnt_d;
    logic [RES_W-1:0]   shreg_q,  shreg_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic [ACC_W:0]     addend;
    logic [ACC_W:0]     sum;
    logic [K_W-1:0]     sa_clamped;
    logic [K_W-1:0]     sb_clamped;
`ifdef APPROX_ROUND_EN
    logic [RES_W-1:0]   round_mask;
`endif

    // Shift counts larger than the mantissa width saturate at MANT_W.
    function automatic logic [K_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        if (s > SHIFT_W'(MANT_W)) begin
            return K_W'(MANT_W);
        end
        return K_W'(s);
    endfunction

    // Clamped operand shifts, used only at the capture edge.
    always_comb begin
        sa_clamped = clamp_shift(a_shift);
        sb_clamped = clamp_shift(b_shift);
    end

    // One add-shift iteration: add the left-aligned multiplicand when the
    // multiplier LSB is set; the extra top bit keeps the carry for the shift.
    always_comb begin
        addend = '0;
        if (mplier_q[0]) begin
            addend = {1'b0, mcand_q, {MANT_W{1'b0}}};
        end
        sum = {1'b0, acc_q} + addend;
    end

`ifdef APPROX_ROUND_EN
    // Bit k-1 of the denormalized product; zero when k is zero.
    always_comb begin
        round_mask = (RES_W'(1) << k_q) >> 1;
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        dcnt_d   = dcnt_q;
        shreg_d  = shreg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a_mant;
                    mplier_d = b_mant;
                    k_d      = K_W'(ACC_W) - sa_clamped - sb_clamped;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MULT;
                end
            end

            S_MULT: begin
                // The accumulator LSB falls into the vacated multiplier MSB,
                // so the pair shifts right as one register.
                acc_d    = sum[ACC_W:1];
                mplier_d = {sum[0], mplier_q[MANT_W-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MANT_W - 1)) begin
                    shreg_d = RES_W'(sum[ACC_W:1]);
                    dcnt_d  = k_q;
                    state_d = S_DENORM;
                end
            end

            S_DENORM: begin
                if (dcnt_q == '0) begin
`ifdef APPROX_ROUND_EN
                    // The low k bits are zero here, so OR-ing cannot carry.
                    result_d = shreg_q | round_mask;
`else
                    result_d = shreg_q;
`endif
                    state_d  = S_DONE;
                end else begin
                    shreg_d = shreg_q << 1;
                    dcnt_d  = dcnt_q - K_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            dcnt_q   <= '0;
            shreg_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            dcnt_q   <= dcnt_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        result    = result_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_approx_mult_denorm.sv
// Self-checking bench for approx_mult_denorm: directed table, hand-written
// corner sequences (ignored starts, mid-operation reset) and random operations
// checked against an arithmetic reference model.
module tb_approx_mult_denorm;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_mant;
  logic [7:0]  b_mant;
  logic [3:0]  a_shift;
  logic [3:0]  b_shift;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  approx_mult_denorm #(.MANT_W(8), .SHIFT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .a_shift   (a_shift),
    .b_shift   (b_shift),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // Reference model: the product of the mantissas, scaled by 2^k.
  function automatic int model_k(input logic [3:0] sa, input logic [3:0] sb);
    int ca;
    int cb;
    ca = (sa > 8) ? 8 : int'(sa);
    cb = (sb > 8) ? 8 : int'(sb);
    return 16 - ca - cb;
  endfunction

  function automatic logic [31:0] model_res(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sa, input logic [3:0] sb);
    int k;
    logic [31:0] r;
    k = model_k(sa, sb);
    r = (32'(a) * 32'(b)) << k;
`ifdef APPROX_ROUND_EN
    if (k >= 1) r[k-1] = 1'b1;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one operation and follow it to done. With disturb set, start is
  // raised again (different operands) before edge 3 and during the done cycle.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic [31:0] exp_res, input int exp_lat, input bit disturb);
    int  n;
    bit  seen;
    bit  busy_bad;
    a_mant  = a;
    b_mant  = b;
    a_shift = sa;
    b_shift = sb;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    a_mant  = 8'($urandom);
    b_mant  = 8'($urandom);
    a_shift = 4'($urandom);
    b_shift = 4'($urandom);
    check({name, " busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    seen = 1'b0;
    busy_bad = 1'b0;
    while (!seen && n < 40) begin
      start = (disturb && n == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
      if (!busy) busy_bad = 1'b1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d edges (expected %0d)", name, n, exp_lat);
    end else begin
      check({name, " busy_held"}, 32'(busy_bad), 32'd0);
      check({name, " result"}, result, exp_res);
      check({name, " latency"}, n, exp_lat);
      if (disturb) begin
        start   = 1'b1;
        a_mant  = 8'h11;
        b_mant  = 8'h22;
        a_shift = 4'd3;
        b_shift = 4'd4;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check({name, " done_pulse"}, 32'(done), 32'd0);
      check({name, " idle_after_done"}, 32'(busy), 32'd0);
      check({name, " result_held"}, result, exp_res);
    end
  endtask

  initial begin
    vec_t v;
    bit   saw_done;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [3:0] rsa;
    logic [3:0] rsb;

    // Directed vectors
`ifdef APPROX_ROUND_EN
    vecs[0] = '{8'hFF, 8'hFF, 4'd0,  4'd0,  32'hFE018000, 25};
    vecs[2] = '{8'h80, 8'h91, 4'd8,  4'd3,  32'h00091010, 14};
    vecs[3] = '{8'h80, 8'h91, 4'd12, 4'd3,  32'h00091010, 14};
    vecs[5] = '{8'h00, 8'h55, 4'd2,  4'd3,  32'h00000400, 20};
    vecs[6] = '{8'h01, 8'h01, 4'd0,  4'd8,  32'h00000180, 17};
`else
    vecs[0] = '{8'hFF, 8'hFF, 4'd0,  4'd0,  32'hFE010000, 25};
    vecs[2] = '{8'h80, 8'h91, 4'd8,  4'd3,  32'h00091000, 14};
    vecs[3] = '{8'h80, 8'h91, 4'd12, 4'd3,  32'h00091000, 14};
    vecs[5] = '{8'h00, 8'h55, 4'd2,  4'd3,  32'h00000000, 20};
    vecs[6] = '{8'h01, 8'h01, 4'd0,  4'd8,  32'h00000100, 17};
`endif
    vecs[1] = '{8'h03, 8'h05, 4'd8,  4'd8,  32'h0000000F, 9};
    vecs[4] = '{8'h80, 8'h91, 4'd8,  4'd15, 32'h00004880, 9};

    // Reset
    rst_n   = 1'b0;
    start   = 1'b0;
    a_mant  = '0;
    b_mant  = '0;
    a_shift = '0;
    b_shift = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v.a, v.b, v.sa, v.sb, v.exp_res, v.exp_lat, 1'b0);
    end

    // Starts while busy and during done are dropped; the next IDLE start works
    v = vecs[0];
    run_op("ignored_starts", v.a, v.b, v.sa, v.sb, v.exp_res, v.exp_lat, 1'b1);
    v = vecs[1];
    run_op("start_after_idle", v.a, v.b, v.sa, v.sb, v.exp_res, v.exp_lat, 1'b0);

    // Reset at edge 5 of an operation
    a_mant  = 8'hFF;
    b_mant  = 8'hFF;
    a_shift = 4'd0;
    b_shift = 4'd0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midreset no_activity", 32'(saw_done), 32'd0);
    v = vecs[2];
    run_op("after_reset", v.a, v.b, v.sa, v.sb, v.exp_res, v.exp_lat, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 25; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsa = 4'($urandom_range(0, 15));
      rsb = 4'($urandom_range(0, 15));
      if (i % 5 == 0) ra = 8'h00;
      run_op($sformatf("rand%0d", i), ra, rb, rsa, rsb,
             model_res(ra, rb, rsa, rsb), 9 + model_k(rsa, rsb), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
